// File: rtl/gmux_hsck_ctrl_if.sv
// Control bundle between the clock-management sequencer and the HSCK global mux.
interface gmux_hsck_ctrl_if;
  logic       REQ_SEL;
  logic [3:0] QUAD_EN;
  logic [3:0] QUAD_LP;
  logic [3:0] DYN_MODE;
  logic [3:0] DYN_GATE;
  logic       SSEL;
  logic [3:0] Q_SEN;
  logic [3:0] Q_DEN;
  logic [3:0] Q_DYNEN;
  logic [3:0] Q_VLP;
  logic       BUSY;
  logic       DONE;

  modport master (
    output REQ_SEL, QUAD_EN, QUAD_LP, DYN_MODE, DYN_GATE,
    input  SSEL, Q_SEN, Q_DEN, Q_DYNEN, Q_VLP, BUSY, DONE
  );

  modport slave (
    input  REQ_SEL, QUAD_EN, QUAD_LP, DYN_MODE, DYN_GATE,
    output SSEL, Q_SEN, Q_DEN, Q_DYNEN, Q_VLP, BUSY, DONE
  );
endinterface

// File: rtl/gmux_hsck_ctrl.sv
// Glitch-safe HSCK/GCLKIN switchover sequencer with per-quadrant low-power sequencing.
// All outputs registered; a switchover takes 3*SETTLE_CYCLES cycles, requests are ignored while BUSY.
module gmux_hsck_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic        RESET_SEL     = 1'b0
) (
  input  logic               QCK,
  input  logic               QRT,
  gmux_hsck_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GATE,
    ST_SWITCH,
    ST_UNGATE
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ssel_q, ssel_d;
  logic [3:0] sen_q, sen_d;
  logic [3:0] den_q, den_d;
  logic [3:0] dynen_q, dynen_d;
  logic [3:0] vlp_q, vlp_d;
  logic [3:0] en_hold_q, en_hold_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ssel_d    = ssel_q;
    sen_d     = sen_q;
    den_d     = den_q;
    dynen_d   = dynen_q;
    vlp_d     = vlp_q;
    en_hold_d = en_hold_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (bus.REQ_SEL != ssel_q) begin
          state_d   = ST_GATE;
          cnt_d     = CNT_LOAD;
          en_hold_d = bus.QUAD_EN;
          sen_d     = 4'b0;
          den_d     = 4'b0;
          dynen_d   = 4'b0;
          busy_d    = 1'b1;
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (bus.QUAD_LP[i] && !vlp_q[i]) begin
              // Quadrant must be dark for a full cycle before VLP may rise.
              sen_d[i]   = 1'b0;
              den_d[i]   = 1'b0;
              dynen_d[i] = 1'b0;
              vlp_d[i]   = !(sen_q[i] || den_q[i]);
            end else if (bus.QUAD_LP[i] || vlp_q[i]) begin
              // Either staying in low power, or leaving it: enables stay off this cycle.
              sen_d[i]   = 1'b0;
              den_d[i]   = 1'b0;
              dynen_d[i] = 1'b0;
              vlp_d[i]   = bus.QUAD_LP[i];
            end else begin
              sen_d[i]   = bus.QUAD_EN[i];
              den_d[i]   = bus.QUAD_EN[i] & bus.DYN_MODE[i];
              dynen_d[i] = bus.QUAD_EN[i] & bus.DYN_MODE[i] & bus.DYN_GATE[i];
            end
          end
        end
      end

      ST_GATE: begin
        sen_d   = 4'b0;
        den_d   = 4'b0;
        dynen_d = 4'b0;
        busy_d  = 1'b1;
        if (cnt_q == 4'd0) begin
          ssel_d  = ~ssel_q;
          state_d = ST_SWITCH;
          cnt_d   = CNT_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_SWITCH: begin
        sen_d   = 4'b0;
        den_d   = 4'b0;
        dynen_d = 4'b0;
        busy_d  = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = ST_UNGATE;
          cnt_d   = CNT_LOAD;
          sen_d   = en_hold_q & ~vlp_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_UNGATE: begin
        sen_d   = en_hold_q & ~vlp_q;
        den_d   = 4'b0;
        dynen_d = 4'b0;
        busy_d  = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      ssel_q    <= RESET_SEL;
      sen_q     <= 4'b0;
      den_q     <= 4'b0;
      dynen_q   <= 4'b0;
      vlp_q     <= 4'b0;
      en_hold_q <= 4'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ssel_q    <= ssel_d;
      sen_q     <= sen_d;
      den_q     <= den_d;
      dynen_q   <= dynen_d;
      vlp_q     <= vlp_d;
      en_hold_q <= en_hold_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.SSEL    = ssel_q;
  assign bus.Q_SEN   = sen_q;
  assign bus.Q_DEN   = den_q;
  assign bus.Q_DYNEN = dynen_q;
  assign bus.Q_VLP   = vlp_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;

endmodule

// File: tb/tb_gmux_hsck_ctrl.sv
// Directed bench for gmux_hsck_ctrl: main instance with S=4, second instance with S=1.
module tb_gmux_hsck_ctrl;

  logic QCK = 1'b0;
  logic QRT;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic prev_ssel;

  gmux_hsck_ctrl_if bus ();
  gmux_hsck_ctrl_if bus1 ();

  gmux_hsck_ctrl #(.SETTLE_CYCLES(4), .RESET_SEL(1'b0)) u_dut (
    .QCK (QCK),
    .QRT (QRT),
    .bus (bus.slave)
  );

  gmux_hsck_ctrl #(.SETTLE_CYCLES(1), .RESET_SEL(1'b0)) u_dut_s1 (
    .QCK (QCK),
    .QRT (QRT),
    .bus (bus1.slave)
  );

  always #5 QCK = ~QCK;

  task automatic tick();
    @(posedge QCK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Mux safety properties sampled on every falling edge.
  always @(negedge QCK) begin
    n_tests++;
    assert ((bus.Q_VLP & (bus.Q_SEN | bus.Q_DEN)) === 4'b0) else begin
      n_fail++;
      $error("FAIL vlp_overlap: observed vlp=%h sen=%h den=%h expected no overlap",
             bus.Q_VLP, bus.Q_SEN, bus.Q_DEN);
    end
    if (bus.SSEL !== prev_ssel) begin
      n_tests++;
      assert ((bus.Q_SEN | bus.Q_DEN) === 4'b0) else begin
        n_fail++;
        $error("FAIL ssel_live: observed sen|den=%h expected 0", bus.Q_SEN | bus.Q_DEN);
      end
    end
    prev_ssel <= bus.SSEL;
  end

  initial begin
    QRT           = 1'b1;
    bus.REQ_SEL   = 1'b0;
    bus.QUAD_EN   = 4'h0;
    bus.QUAD_LP   = 4'h0;
    bus.DYN_MODE  = 4'h0;
    bus.DYN_GATE  = 4'h0;
    bus1.REQ_SEL  = 1'b0;
    bus1.QUAD_EN  = 4'h0;
    bus1.QUAD_LP  = 4'h0;
    bus1.DYN_MODE = 4'h0;
    bus1.DYN_GATE = 4'h0;
    ticks(2);

    // Reset state
    check("rst_ssel",  {3'b0, bus.SSEL}, 4'h0);
    check("rst_sen",   bus.Q_SEN,   4'h0);
    check("rst_den",   bus.Q_DEN,   4'h0);
    check("rst_dynen", bus.Q_DYNEN, 4'h0);
    check("rst_vlp",   bus.Q_VLP,   4'h0);
    check("rst_busy",  {3'b0, bus.BUSY}, 4'h0);
    check("rst_done",  {3'b0, bus.DONE}, 4'h0);

    // Release with all quadrants requested
    bus.QUAD_EN  = 4'hF;
    bus1.QUAD_EN = 4'hF;
    QRT          = 1'b0;
    tick();
    check("rel_sen",    bus.Q_SEN,  4'hF);
    check("rel_sen_s1", bus1.Q_SEN, 4'hF);

    // Switchover 0->1; c counts edges from the one that samples the mismatch
    bus.REQ_SEL  = 1'b1;
    bus1.REQ_SEL = 1'b1;
    for (int c = 0; c <= 13; c++) begin
      tick();
      check($sformatf("sw_sen_c%0d", c),  bus.Q_SEN, (c >= 8) ? 4'hF : 4'h0);
      check($sformatf("sw_ssel_c%0d", c), {3'b0, bus.SSEL}, (c >= 4) ? 4'h1 : 4'h0);
      check($sformatf("sw_busy_c%0d", c), {3'b0, bus.BUSY}, (c <= 11) ? 4'h1 : 4'h0);
      check($sformatf("sw_done_c%0d", c), {3'b0, bus.DONE}, (c == 12) ? 4'h1 : 4'h0);
      if (c <= 4) begin
        check($sformatf("s1_ssel_c%0d", c), {3'b0, bus1.SSEL}, (c >= 1) ? 4'h1 : 4'h0);
        check($sformatf("s1_sen_c%0d", c),  bus1.Q_SEN, (c >= 2) ? 4'hF : 4'h0);
        check($sformatf("s1_busy_c%0d", c), {3'b0, bus1.BUSY}, (c <= 2) ? 4'h1 : 4'h0);
        check($sformatf("s1_done_c%0d", c), {3'b0, bus1.DONE}, (c == 3) ? 4'h1 : 4'h0);
      end
    end

    // Request 1->0, flipped back during SWITCH: completes, then restarts at once
    bus.REQ_SEL = 1'b0;
    tick();
    check("tb_busy_c0", {3'b0, bus.BUSY}, 4'h1);
    ticks(4);
    check("tb_ssel_c4", {3'b0, bus.SSEL}, 4'h0);
    bus.REQ_SEL = 1'b1;
    ticks(8);
    check("tb_done_c12", {3'b0, bus.DONE}, 4'h1);
    check("tb_ssel_c12", {3'b0, bus.SSEL}, 4'h0);
    check("tb_busy_c12", {3'b0, bus.BUSY}, 4'h0);
    tick();
    check("tb_busy_c13", {3'b0, bus.BUSY}, 4'h1);
    check("tb_sen_c13",  bus.Q_SEN, 4'h0);
    check("tb_done_c13", {3'b0, bus.DONE}, 4'h0);
    ticks(12);
    check("tb_done_c25", {3'b0, bus.DONE}, 4'h1);
    check("tb_ssel_c25", {3'b0, bus.SSEL}, 4'h1);
    tick();
    check("tb_sen_c26",  bus.Q_SEN, 4'hF);
    check("tb_done_c26", {3'b0, bus.DONE}, 4'h0);

    // Low-power entry and exit on TL
    bus.QUAD_LP = 4'b0001;
    tick();
    check("lp_in_sen1", bus.Q_SEN, 4'hE);
    check("lp_in_vlp1", bus.Q_VLP, 4'h0);
    tick();
    check("lp_in_vlp2", bus.Q_VLP, 4'h1);
    check("lp_in_sen2", bus.Q_SEN, 4'hE);
    tick();
    check("lp_hold_vlp", bus.Q_VLP, 4'h1);
    bus.QUAD_LP = 4'b0000;
    tick();
    check("lp_out_vlp1", bus.Q_VLP, 4'h0);
    check("lp_out_sen1", bus.Q_SEN, 4'hE);
    tick();
    check("lp_out_sen2", bus.Q_SEN, 4'hF);

    // Dynamic gating, then a switchover that must silence it
    bus.DYN_MODE = 4'b1010;
    bus.DYN_GATE = 4'b1111;
    tick();
    check("dyn_den1",   bus.Q_DEN,   4'hA);
    check("dyn_dynen1", bus.Q_DYNEN, 4'hA);
    bus.DYN_GATE = 4'b0010;
    tick();
    check("dyn_dynen2", bus.Q_DYNEN, 4'h2);
    bus.DYN_GATE = 4'b1000;
    tick();
    check("dyn_dynen3", bus.Q_DYNEN, 4'h8);
    bus.REQ_SEL = 1'b0;
    tick();
    check("dsw_den_c0",   bus.Q_DEN,   4'h0);
    check("dsw_dynen_c0", bus.Q_DYNEN, 4'h0);
    ticks(4);
    check("dsw_den_c4",  bus.Q_DEN, 4'h0);
    check("dsw_ssel_c4", {3'b0, bus.SSEL}, 4'h0);
    ticks(4);
    check("dsw_sen_c8",   bus.Q_SEN,   4'hF);
    check("dsw_den_c8",   bus.Q_DEN,   4'h0);
    check("dsw_dynen_c8", bus.Q_DYNEN, 4'h0);
    ticks(4);
    check("dsw_done_c12", {3'b0, bus.DONE}, 4'h1);
    check("dsw_den_c12",  bus.Q_DEN, 4'h0);
    tick();
    check("dsw_den_c13",   bus.Q_DEN,   4'hA);
    check("dsw_dynen_c13", bus.Q_DYNEN, 4'h8);

    // Park BL in low power, then reset in the middle of GATE
    bus.QUAD_LP = 4'b0100;
    ticks(2);
    check("pre_rst_vlp", bus.Q_VLP, 4'h4);
    check("pre_rst_sen", bus.Q_SEN, 4'hB);
    bus.REQ_SEL = 1'b1;
    tick();
    check("mid_busy", {3'b0, bus.BUSY}, 4'h1);
    check("mid_vlp",  bus.Q_VLP, 4'h4);
    tick();
    QRT = 1'b1;
    #1;
    check("arst_ssel",  {3'b0, bus.SSEL}, 4'h0);
    check("arst_sen",   bus.Q_SEN,   4'h0);
    check("arst_den",   bus.Q_DEN,   4'h0);
    check("arst_dynen", bus.Q_DYNEN, 4'h0);
    check("arst_vlp",   bus.Q_VLP,   4'h0);
    check("arst_busy",  {3'b0, bus.BUSY}, 4'h0);
    check("arst_done",  {3'b0, bus.DONE}, 4'h0);
    bus.REQ_SEL  = 1'b0;
    bus.QUAD_LP  = 4'b0000;
    bus.DYN_MODE = 4'b0000;
    tick();
    QRT = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      check($sformatf("post_rst_done_%0d", c), {3'b0, bus.DONE}, 4'h0);
      check($sformatf("post_rst_busy_%0d", c), {3'b0, bus.BUSY}, 4'h0);
    end
    check("post_rst_sen",  bus.Q_SEN, 4'hF);
    check("post_rst_ssel", {3'b0, bus.SSEL}, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
